// File: rtl/sprite_mover.sv
// Single rectangular sprite on the 160x120 VGA canvas: draw, wait a number of frame
// ticks, erase, apply queued player input, redraw. Drives the VGA pixel port and score.
module sprite_mover #(
  parameter int       SPR_W     = 4,
  parameter int       SPR_H     = 4,
  parameter int       X_INIT    = 78,
  parameter int       Y_INIT    = 105,
  parameter int       X_MAX     = 156,
  parameter int       X_STEP    = 1,
  parameter int       Y_STEP    = 20,
  parameter int       DELAY     = 53332,
  parameter int       FRAMES    = 8,
  parameter logic [2:0] FG_COLOUR = 3'b011,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK,
  input  logic       resetn,
  input  logic       go,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic [7:0] score
);

  localparam int DW = (DELAY  > 1) ? $clog2(DELAY + 1)  : 1;
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES + 1) : 1;
  localparam logic [8:0] X_STEP9 = 9'(X_STEP);
  localparam logic [8:0] X_MAX9  = 9'(X_MAX);
  localparam logic [7:0] Y_STEP8 = 8'(Y_STEP);
  localparam logic [7:0] X_INIT8 = 8'(X_INIT);
  localparam logic [6:0] Y_INIT7 = 7'(Y_INIT);
  localparam logic [3:0] CX_LAST = 4'(SPR_W - 1);
  localparam logic [3:0] CY_LAST = 4'(SPR_H - 1);
  localparam logic [DW-1:0] DELAY_LAST  = DW'(DELAY - 1);
  localparam logic [FW-1:0] FRAMES_LAST = FW'(FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GO_WAIT, S_DRAW, S_WAIT, S_ERASE, S_UPDATE
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    pos_x_r, pos_x_s;
  logic [6:0]    pos_y_r, pos_y_s;
  logic [3:0]    cx_r, cy_r;
  logic [DW-1:0] delay_r;
  logic [FW-1:0] frame_r;
  logic          jump_q_r, jump_pend_r;
  logic [7:0]    score_r, score_s;
  logic          raster_s, last_px_s, tick_s, wait_done_s, jump_edge_s, armed_s;
  logic [8:0]    sum_x_s;

  assign raster_s    = (state_r == S_DRAW) || (state_r == S_ERASE);
  assign last_px_s   = (cx_r == CX_LAST) && (cy_r == CY_LAST);
  assign tick_s      = (delay_r == DELAY_LAST);
  assign wait_done_s = tick_s && (frame_r == FRAMES_LAST);
  assign jump_edge_s = jump & ~jump_q_r;
  assign armed_s     = (state_r != S_IDLE) && (state_r != S_GO_WAIT);
  assign sum_x_s     = {1'b0, pos_x_r} + X_STEP9;

  // State register
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:    if (go) state_s = S_GO_WAIT;        else state_s = S_IDLE;
      S_GO_WAIT: if (!go) state_s = S_DRAW;          else state_s = S_GO_WAIT;
      S_DRAW:    if (last_px_s) state_s = S_WAIT;    else state_s = S_DRAW;
      S_WAIT:    if (wait_done_s) state_s = S_ERASE; else state_s = S_WAIT;
      S_ERASE:   if (last_px_s) state_s = S_UPDATE;  else state_s = S_ERASE;
      S_UPDATE:  state_s = S_DRAW;
      default:   state_s = S_IDLE;
    endcase
  end

  // Raster column/row counters, row advances when the column wraps
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      cx_r <= 4'd0;
      cy_r <= 4'd0;
    end else if (raster_s) begin
      if (cx_r == CX_LAST) begin
        cx_r <= 4'd0;
        cy_r <= last_px_s ? 4'd0 : cy_r + 4'd1;
      end else begin
        cx_r <= cx_r + 4'd1;
        cy_r <= cy_r;
      end
    end else begin
      cx_r <= cx_r;
      cy_r <= cy_r;
    end
  end

  // Frame-tick timing, held at zero outside WAIT so every WAIT starts fresh
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      delay_r <= '0;
      frame_r <= '0;
    end else if (state_r == S_WAIT) begin
      if (tick_s) begin
        delay_r <= '0;
        frame_r <= frame_r + FW'(1);
      end else begin
        delay_r <= delay_r + DW'(1);
        frame_r <= frame_r;
      end
    end else begin
      delay_r <= '0;
      frame_r <= '0;
    end
  end

  // Jump edge capture; a fresh edge during UPDATE survives the clear
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      jump_q_r    <= 1'b0;
      jump_pend_r <= 1'b0;
    end else begin
      jump_q_r <= jump;
      if (armed_s && jump_edge_s)  jump_pend_r <= 1'b1;
      else if (state_r == S_UPDATE) jump_pend_r <= 1'b0;
      else                          jump_pend_r <= jump_pend_r;
    end
  end

  // Clamped movement and saturating score for the UPDATE cycle
  always_comb begin
    pos_x_s = pos_x_r;
    pos_y_s = pos_y_r;
    score_s = score_r;
    if (move_left && !move_right) begin
      if ({1'b0, pos_x_r} >= X_STEP9) pos_x_s = pos_x_r - X_STEP9[7:0];
      else                            pos_x_s = 8'd0;
    end else if (move_right && !move_left) begin
      if (sum_x_s <= X_MAX9) pos_x_s = sum_x_s[7:0];
      else                   pos_x_s = X_MAX9[7:0];
    end else begin
      pos_x_s = pos_x_r;
    end
    if (jump_pend_r) begin
      if ({1'b0, pos_y_r} > Y_STEP8) pos_y_s = pos_y_r - Y_STEP8[6:0];
      else                           pos_y_s = Y_INIT7;
      score_s = (score_r == 8'd255) ? 8'd255 : score_r + 8'd1;
    end else begin
      pos_y_s = pos_y_r;
      score_s = score_r;
    end
  end

  // Position and score registers
  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      pos_x_r <= X_INIT8;
      pos_y_r <= Y_INIT7;
      score_r <= 8'd0;
    end else if (state_r == S_UPDATE) begin
      pos_x_r <= pos_x_s;
      pos_y_r <= pos_y_s;
      score_r <= score_s;
    end else begin
      pos_x_r <= pos_x_r;
      pos_y_r <= pos_y_r;
      score_r <= score_r;
    end
  end

  // Pixel port
  always_comb begin
    x       = pos_x_r + {4'd0, cx_r};
    y       = pos_y_r + {3'd0, cy_r};
    writeEn = raster_s;
    busy    = raster_s;
    score   = score_r;
    if (state_r == S_ERASE) colour = BG_COLOUR;
    else                    colour = FG_COLOUR;
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: stimulus pushes expected pixel writes computed from
// a plain position/score model; a monitor pops and checks every write.
module tb_sprite_mover;
  localparam int SW = 8, SH = 2, XI = 78, YI = 105, XM = 152, XS = 7, YS = 20;
  localparam int DL = 4, FR = 2, FG = 3, BG = 0;

  logic       CLOCK = 1'b0;
  logic       resetn, go, move_left, move_right, jump;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy;
  logic [7:0] score;

  sprite_mover #(
    .SPR_W(SW), .SPR_H(SH), .X_INIT(XI), .Y_INIT(YI), .X_MAX(XM), .X_STEP(XS),
    .Y_STEP(YS), .DELAY(DL), .FRAMES(FR), .FG_COLOUR(3'b011), .BG_COLOUR(3'b000)
  ) dut (
    .CLOCK(CLOCK), .resetn(resetn), .go(go), .move_left(move_left),
    .move_right(move_right), .jump(jump), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .busy(busy), .score(score)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {int x; int y; int col; int score; int gap;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  int mx, my, mscore;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Queue one full raster at the model position; gap = idle cycles before first pixel
  function automatic void push_raster(input int col, input int first_gap);
    exp_t e;
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++) begin
        e.x = mx + c; e.y = my + r; e.col = col; e.score = mscore;
        e.gap = (r == 0 && c == 0) ? first_gap : 0;
        sb.push_back(e);
      end
  endfunction

  // Monitor: every write must match the head of the scoreboard
  initial begin : monitor
    exp_t e;
    int idle;
    idle = 0;
    forever begin
      @(negedge CLOCK);
      if (!resetn) idle = 0;
      else if (writeEn) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got x=%0d y=%0d colour=%0d, expected no write", x, y, colour);
        end else begin
          e = sb.pop_front();
          if (x !== 8'(e.x) || y !== 7'(e.y) || colour !== 3'(e.col) || score !== 8'(e.score) ||
              (e.gap >= 0 && idle != e.gap)) begin
            fails++;
            $display("FAIL pixel: got x=%0d y=%0d colour=%0d score=%0d gap=%0d, expected x=%0d y=%0d colour=%0d score=%0d gap=%0d",
                     x, y, colour, score, idle, e.x, e.y, e.col, e.score, e.gap);
          end
        end
        idle = 0;
      end else idle++;
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic wait_busy(input logic val);
    for (int i = 0; i < 200; i++) begin
      @(posedge CLOCK); #1;
      if (busy === val) return;
    end
    tests++; fails++;
    $display("FAIL busy_timeout: busy never became %0d", val);
    finish_run();
  endtask

  task automatic start_run();
    mx = XI; my = YI; mscore = 0;
    push_raster(FG, -1);
    go = 1'b1;
    repeat (3) begin @(posedge CLOCK); #1; end
    go = 1'b0;
    chk("go_wait_no_write", {31'd0, writeEn}, 32'd0);
    @(posedge CLOCK); #1;
    chk("first_write_latency", {31'd0, writeEn}, 32'd1);
  endtask

  // One frame: inputs applied during WAIT, model advanced exactly as the rules state
  task automatic do_frame(input logic l, input logic r, input int nj);
    wait_busy(1'b0);
    move_left = l; move_right = r;
    for (int p = 0; p < nj; p++) begin
      jump = 1'b1; @(posedge CLOCK); #1;
      jump = 1'b0; @(posedge CLOCK); #1;
    end
    push_raster(BG, DL * FR);
    if (l && !r)      mx = (mx >= XS) ? mx - XS : 0;
    else if (r && !l) mx = (mx + XS <= XM) ? mx + XS : XM;
    if (nj > 0) begin
      my = (my > YS) ? my - YS : YI;
      mscore = (mscore == 255) ? 255 : mscore + 1;
    end
    push_raster(FG, 1);
    wait_busy(1'b1);
    wait_busy(1'b0);
    wait_busy(1'b1);
    move_left = 1'b0; move_right = 1'b0;
  endtask

  initial begin : stim
    logic [1:0] lr;
    resetn = 1'b0; go = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    repeat (3) begin @(posedge CLOCK); #1; end
    chk("rst_writeEn", {31'd0, writeEn}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_x", {24'd0, x}, XI);
    chk("rst_y", {25'd0, y}, YI);
    chk("rst_colour", {29'd0, colour}, FG);
    chk("rst_score", {24'd0, score}, 32'd0);
    resetn = 1'b1;
    repeat (5) begin @(posedge CLOCK); #1; end
    start_run();

    do_frame(1'b0, 1'b0, 0);
    do_frame(1'b0, 1'b1, 1);
    do_frame(1'b1, 1'b1, 0);
    do_frame(1'b1, 1'b0, 3);

    for (int k = 0; k < 30; k++) begin
      if (k == 15) begin
        repeat (7) begin @(posedge CLOCK); #1; end
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("midraster_rst_writeEn", {31'd0, writeEn}, 32'd0);
        chk("midraster_rst_x", {24'd0, x}, XI);
        chk("midraster_rst_y", {25'd0, y}, YI);
        chk("midraster_rst_score", {24'd0, score}, 32'd0);
        @(posedge CLOCK); #1;
        resetn = 1'b1;
        repeat (10) begin @(posedge CLOCK); #1; end
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        start_run();
      end
      lr = 2'($urandom_range(0, 3));
      do_frame(lr[1], lr[0], $urandom_range(0, 3));
    end

    for (int k = 0; k < 265; k++) begin
      lr = ((k / 25) % 2 == 0) ? 2'b01 : 2'b10;
      if ($urandom_range(0, 7) == 0) lr = 2'($urandom_range(0, 3));
      do_frame(lr[1], lr[0], ($urandom_range(0, 9) == 0) ? 2 : 1);
    end

    wait_busy(1'b0);
    chk("score_saturated", {24'd0, score}, mscore);
    chk("scoreboard_drained", sb.size(), 32'd0);
    finish_run();
  end
endmodule
